// File: rtl/imem_fetch_port_if.sv
// Fetch-port bundle: valid/ready request/response plus the program-write port.
// The master side is the fetch stage or programmer; the slave side is the memory.
interface imem_fetch_port_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_fault;
  logic              flush;
  logic              wea;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport master (
    output req_valid, req_addr, rsp_ready, flush, wea, waddr, wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, wea, waddr, wdata,
    output req_ready, rsp_valid, rsp_data, rsp_fault
  );
endinterface

// File: rtl/imem_fetch_port.sv
// Instruction memory with a registered, 1-cycle-latency valid/ready fetch port,
// range/alignment fault reporting, fetch flush and an independent program-write port.
module imem_fetch_port #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 32,
  parameter bit                BYTE_ADDR = 1'b0,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
  input  logic            clka,
  input  logic            rsta_n,
  imem_fetch_port_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t state, state_n;

  // Filled with NOP_WORD at power-up only; reset never touches the array.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

  logic [ADDR_W-1:0] ridx_full, widx_full;
  logic [IDX_W-1:0]  ridx, widx;
  logic              rd_ok, wr_ok, wr_en;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] data_q;
  logic              fault_q;
  logic              ready_c, accept_c;

  // Address decode; upper bits take part in the range compare so they fault.
  assign ridx_full = BYTE_ADDR ? (bus.req_addr >> 2) : bus.req_addr;
  assign widx_full = BYTE_ADDR ? (bus.waddr >> 2)    : bus.waddr;
  assign ridx      = ridx_full[IDX_W-1:0];
  assign widx      = widx_full[IDX_W-1:0];
  assign rd_ok     = (ridx_full < ADDR_W'(DEPTH)) && !(BYTE_ADDR && (bus.req_addr[1:0] != 2'b00));
  assign wr_ok     = (widx_full < ADDR_W'(DEPTH)) && !(BYTE_ADDR && (bus.waddr[1:0]    != 2'b00));
  assign wr_en     = bus.wea && wr_ok;

  // Write-first bypass when a write and a fetch hit the same word on one edge.
  assign rd_word = (wr_en && (widx == ridx)) ? bus.wdata : mem[ridx];

  assign ready_c  = !bus.flush && ((state == S_EMPTY) || bus.rsp_ready);
  assign accept_c = bus.req_valid && ready_c;

  always_ff @(posedge clka) begin
    if (wr_en) begin
      mem[widx] <= bus.wdata;
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state   <= S_EMPTY;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept_c) begin
        data_q  <= rd_ok ? rd_word : NOP_WORD;
        fault_q <= !rd_ok;
      end
    end
  end

  // Flush beats both stall and accept; a consume without accept drains the slot.
  always_comb begin
    state_n = state;
    case (state)
      S_EMPTY: begin
        if (accept_c) state_n = S_FULL;
      end
      S_FULL: begin
        if (bus.flush)                       state_n = S_EMPTY;
        else if (!accept_c && bus.rsp_ready) state_n = S_EMPTY;
      end
      default: state_n = S_EMPTY;
    endcase
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = (state == S_FULL);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed table-driven bench for imem_fetch_port: a word-addressed instance
// (NOP_WORD=0) and a byte-addressed instance (NOP_WORD=0x13).
module tb_imem_fetch_port;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_fetch_port_if #(.ADDR_W(32), .DATA_W(32)) i0 ();
  imem_fetch_port_if #(.ADDR_W(32), .DATA_W(32)) i1 ();

  imem_fetch_port #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .BYTE_ADDR(1'b0),
                    .NOP_WORD(32'h0000_0000)) u0 (.clka(clk), .rsta_n(rst_n), .bus(i0));
  imem_fetch_port #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .BYTE_ADDR(1'b1),
                    .NOP_WORD(32'h0000_0013)) u1 (.clka(clk), .rsta_n(rst_n), .bus(i1));

  typedef struct {
    bit          b;
    bit          we;
    logic [31:0] wa;
    logic [31:0] wd;
    bit          rv;
    logic [31:0] ra;
    bit          rr;
    bit          fl;
    bit          e_rdy;
    bit          e_val;
    logic [31:0] e_dat;
    bit          e_flt;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(bit b, bit we, logic [31:0] wa, logic [31:0] wd,
                              bit rv, logic [31:0] ra, bit rr, bit fl,
                              bit er, bit ev, logic [31:0] ed, bit ef);
    vec_t v;
    v.b = b; v.we = we; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra;
    v.rr = rr; v.fl = fl; v.e_rdy = er; v.e_val = ev; v.e_dat = ed; v.e_flt = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic idle();
    i0.req_valid = 1'b0; i0.req_addr = '0; i0.rsp_ready = 1'b1; i0.flush = 1'b0;
    i0.wea = 1'b0; i0.waddr = '0; i0.wdata = '0;
    i1.req_valid = 1'b0; i1.req_addr = '0; i1.rsp_ready = 1'b1; i1.flush = 1'b0;
    i1.wea = 1'b0; i1.waddr = '0; i1.wdata = '0;
  endtask

  // Drive one vector at negedge, check req_ready before the edge, outputs after it.
  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    idle();
    if (v.b) begin
      i1.wea = v.we; i1.waddr = v.wa; i1.wdata = v.wd; i1.req_valid = v.rv;
      i1.req_addr = v.ra; i1.rsp_ready = v.rr; i1.flush = v.fl;
    end else begin
      i0.wea = v.we; i0.waddr = v.wa; i0.wdata = v.wd; i0.req_valid = v.rv;
      i0.req_addr = v.ra; i0.rsp_ready = v.rr; i0.flush = v.fl;
    end
    #1;
    chk("req_ready", idx, 32'(v.b ? i1.req_ready : i0.req_ready), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    chk("rsp_valid", idx, 32'(v.b ? i1.rsp_valid : i0.rsp_valid), 32'(v.e_val));
    chk("rsp_data",  idx, v.b ? i1.rsp_data : i0.rsp_data, v.e_dat);
    chk("rsp_fault", idx, 32'(v.b ? i1.rsp_fault : i0.rsp_fault), 32'(v.e_flt));
  endtask

  initial begin
    idle();
    //              b we wa          wd            rv ra          rr fl  rdy val data          flt
    // program and back-to-back fetch
    tbl.push_back(mk(0,1,32'd1,      32'h24430003, 0,32'd0,      1,0,  1,0,32'h00000000,0));
    tbl.push_back(mk(0,1,32'd2,      32'h20410003, 0,32'd0,      1,0,  1,0,32'h00000000,0));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd1,      1,0,  1,1,32'h24430003,0));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd2,      1,0,  1,1,32'h20410003,0));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        0,32'd0,      1,0,  1,0,32'h20410003,0));
    // stall for three cycles, then release with a same-cycle accept
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd1,      0,0,  1,1,32'h24430003,0));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd2,      0,0,  0,1,32'h24430003,0));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd2,      0,0,  0,1,32'h24430003,0));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd2,      0,0,  0,1,32'h24430003,0));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd2,      1,0,  1,1,32'h20410003,0));
    // range: idx 32, high address bit, last valid idx (power-up fill)
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd32,     1,0,  1,1,32'h00000000,1));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'h80000001,1,0, 1,1,32'h00000000,1));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd31,     1,0,  1,1,32'h00000000,0));
    // write-first collision, write to held idx, flush
    tbl.push_back(mk(0,1,32'd3,      32'hDEADBEEF, 1,32'd3,      1,0,  1,1,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd1,      1,0,  1,1,32'h24430003,0));
    tbl.push_back(mk(0,1,32'd1,      32'h11111111, 0,32'd0,      0,0,  0,1,32'h24430003,0));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd2,      0,1,  0,0,32'h24430003,0));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd1,      1,0,  1,1,32'h11111111,0));
    // out-of-range write must not alias onto idx 8
    tbl.push_back(mk(0,1,32'd40,     32'h55555555, 0,32'd0,      1,0,  1,0,32'h11111111,0));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd8,      1,0,  1,1,32'h00000000,0));
    tbl.push_back(mk(0,0,32'd0,      32'h0,        1,32'd2,      1,1,  0,0,32'h00000000,0));
    // byte-addressed instance
    tbl.push_back(mk(1,1,32'h8,      32'h20410003, 0,32'h0,      1,0,  1,0,32'h00000000,0));
    tbl.push_back(mk(1,1,32'h6,      32'h0BAD0BAD, 0,32'h0,      1,0,  1,0,32'h00000000,0));
    tbl.push_back(mk(1,0,32'h0,      32'h0,        1,32'h6,      1,0,  1,1,32'h00000013,1));
    tbl.push_back(mk(1,0,32'h0,      32'h0,        1,32'h8,      1,0,  1,1,32'h20410003,0));
    tbl.push_back(mk(1,0,32'h0,      32'h0,        1,32'h4,      1,0,  1,1,32'h00000013,0));
    tbl.push_back(mk(1,0,32'h0,      32'h0,        1,32'h80,     1,0,  1,1,32'h00000013,1));
    tbl.push_back(mk(1,0,32'h0,      32'h0,        1,32'h7C,     1,0,  1,1,32'h00000013,0));
    tbl.push_back(mk(1,0,32'h0,      32'h0,        0,32'h0,      1,0,  1,0,32'h00000013,0));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid0", 0, 32'(i0.rsp_valid), 32'd0);
    chk("rst_data0",  0, i0.rsp_data, 32'h0);
    chk("rst_fault0", 0, 32'(i0.rsp_fault), 32'd0);
    chk("rst_valid1", 0, 32'(i1.rsp_valid), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], i);
    end

    // reset while a response is stalled; memory must survive
    step(mk(0,0,32'd0,32'h0, 1,32'd2, 0,0, 1,1,32'h20410003,0), 100);
    step(mk(0,0,32'd0,32'h0, 1,32'd1, 0,0, 0,1,32'h20410003,0), 101);
    @(negedge clk);
    idle();
    i0.rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 102, 32'(i0.rsp_valid), 32'd0);
    chk("midrst_data",  102, i0.rsp_data, 32'h0);
    chk("midrst_fault", 102, 32'(i0.rsp_fault), 32'd0);
    chk("midrst_ready", 102, 32'(i0.req_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    step(mk(0,0,32'd0,32'h0, 1,32'd2, 1,0, 1,1,32'h20410003,0), 103);
    step(mk(0,0,32'd0,32'h0, 0,32'd0, 1,0, 1,0,32'h20410003,0), 104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
